// File: rtl/net_activity_monitor.sv
// Per-net toggle counter over fixed windows of enabled cycles.
// Snapshots each window into a shadow bank and drains it entry by entry.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   en               counting enable (first enabled cycle only primes)
//   nets             monitored nets
//   out_ready        consumer ready
//   out_valid        shadow entry valid
//   out_idx          net index of the current entry
//   out_count        toggle count for out_idx
//   out_sat          count for out_idx saturated
//   out_last         current entry is the final one
//   dropped          sticky flag: a window ended while still draining
module net_activity_monitor #(
  parameter int NUM_NETS  = 8,
  parameter int CNT_WIDTH = 16,
  parameter int WINDOW    = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_NETS-1:0]         nets,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [$clog2(NUM_NETS)-1:0] out_idx,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        out_sat,
  output logic                        out_last,
  output logic                        dropped
);

  localparam int IW = $clog2(NUM_NETS);
  localparam int WW = $clog2(WINDOW);
  localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};
  localparam logic [IW-1:0] ILAST = IW'(NUM_NETS - 1);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   live_q   [NUM_NETS];
  logic [CNT_WIDTH-1:0]   live_d   [NUM_NETS];
  logic [CNT_WIDTH-1:0]   inc_cnt  [NUM_NETS];
  logic [CNT_WIDTH-1:0]   shadow_q [NUM_NETS];
  logic [NUM_NETS-1:0]    lsat_q;
  logic [NUM_NETS-1:0]    lsat_d;
  logic [NUM_NETS-1:0]    inc_sat;
  logic [NUM_NETS-1:0]    ssat_q;
  logic [NUM_NETS-1:0]    prev_q;
  logic                   primed_q;
  logic [WW-1:0]          wcnt_q;
  logic [WW-1:0]          wcnt_d;
  logic [IW-1:0]          idx_q;
  logic                   dropped_q;

  logic count_en;
  logic win_end;
  logic xfer;
  logic xfer_last;
  logic capture;

  assign count_en  = en && primed_q;
  assign win_end   = count_en && (wcnt_q == WLAST);
  assign xfer      = (state_q == DRAIN) && out_ready;
  assign xfer_last = xfer && (idx_q == ILAST);
  // A window ending on the final accepted transfer is taken as idle.
  assign capture   = win_end && ((state_q == IDLE) || xfer_last);

  always_comb begin
    for (int i = 0; i < NUM_NETS; i++) begin
      inc_cnt[i] = live_q[i];
      inc_sat[i] = lsat_q[i];
      if (count_en && (nets[i] ^ prev_q[i])) begin
        if (live_q[i] == CMAX) begin
          inc_sat[i] = 1'b1;
        end else begin
          inc_cnt[i] = live_q[i] + CNT_WIDTH'(1);
        end
      end
      live_d[i] = win_end ? '0 : inc_cnt[i];
    end
    lsat_d = win_end ? '0 : inc_sat;
    wcnt_d = wcnt_q;
    if (win_end) begin
      wcnt_d = '0;
    end else if (count_en) begin
      wcnt_d = wcnt_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      live_q    <= '{default: '0};
      shadow_q  <= '{default: '0};
      lsat_q    <= '0;
      ssat_q    <= '0;
      prev_q    <= '0;
      primed_q  <= 1'b0;
      wcnt_q    <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      live_q <= live_d;
      lsat_q <= lsat_d;
      wcnt_q <= wcnt_d;
      if (en) begin
        prev_q   <= nets;
        primed_q <= 1'b1;
      end else begin
        primed_q <= 1'b0;
      end
      if (win_end && !capture) begin
        dropped_q <= 1'b1;
      end
      if (capture) begin
        shadow_q <= inc_cnt;
        ssat_q   <= inc_sat;
        state_q  <= DRAIN;
        idx_q    <= '0;
      end else if (xfer_last) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign out_idx   = idx_q;
  assign out_count = shadow_q[idx_q];
  assign out_sat   = ssat_q[idx_q];
  assign out_last  = out_valid && (idx_q == ILAST);
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_net_activity_monitor.sv
// Randomized and directed bench for net_activity_monitor.
// Two instances (4-bit and 3-bit counters) share one stimulus stream.
module tb_net_activity_monitor;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] nets = '0;

  logic v4, s4, l4, d4;
  logic [1:0] i4;
  logic [3:0] c4;
  logic v3, s3, l3, d3;
  logic [1:0] i3;
  logic [2:0] c3;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  net_activity_monitor #(.NUM_NETS(N), .CNT_WIDTH(4), .WINDOW(W)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .nets(nets),
    .out_ready(out_ready), .out_valid(v4), .out_idx(i4),
    .out_count(c4), .out_sat(s4), .out_last(l4), .dropped(d4)
  );

  net_activity_monitor #(.NUM_NETS(N), .CNT_WIDTH(3), .WINDOW(W)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .nets(nets),
    .out_ready(out_ready), .out_valid(v3), .out_idx(i3),
    .out_count(c3), .out_sat(s3), .out_last(l3), .dropped(d3)
  );

  // Reference: unbounded toggle totals per window, enabled-cycle tally,
  // and a single pending snapshot that is either draining or absent.
  int m_cnt[N];
  int m_snap[N];
  int m_w;
  int m_idx;
  bit m_primed;
  bit m_busy;
  bit m_drop;
  logic [3:0] m_prev;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_cnt[j]) begin
        m_cnt[j] = 0;
        m_snap[j] = 0;
      end
      m_w = 0;
      m_idx = 0;
      m_primed = 0;
      m_busy = 0;
      m_drop = 0;
      m_prev = '0;
    end else begin
      if (m_busy && out_ready) begin
        if (m_idx == N - 1) begin
          m_busy = 0;
          m_idx = 0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
      if (!en) begin
        m_primed = 0;
      end else if (!m_primed) begin
        m_primed = 1;
        m_prev = nets;
      end else begin
        foreach (m_cnt[j])
          if (nets[j] != m_prev[j]) m_cnt[j] = m_cnt[j] + 1;
        m_prev = nets;
        m_w = m_w + 1;
        if (m_w == W) begin
          m_w = 0;
          if (!m_busy) begin
            m_snap = m_cnt;
            m_busy = 1;
            m_idx = 0;
          end else begin
            m_drop = 1;
          end
          foreach (m_cnt[j]) m_cnt[j] = 0;
        end
      end
    end
  end

  function automatic logic [9:0] exp4();
    int c;
    logic s;
    c = m_busy ? m_snap[m_idx] : 0;
    s = (c > 15);
    if (c > 15) c = 15;
    return {m_busy, 2'(m_idx), 4'(c), s,
            m_busy && (m_idx == N - 1), m_drop};
  endfunction

  function automatic logic [8:0] exp3();
    int c;
    logic s;
    c = m_busy ? m_snap[m_idx] : 0;
    s = (c > 7);
    if (c > 7) c = 7;
    return {m_busy, 2'(m_idx), 3'(c), s,
            m_busy && (m_idx == N - 1), m_drop};
  endfunction

  function automatic logic [9:0] act4();
    return {v4, i4, v4 ? c4 : 4'd0, v4 & s4, l4, d4};
  endfunction

  function automatic logic [8:0] act3();
    return {v3, i3, v3 ? c3 : 3'd0, v3 & s3, l3, d3};
  endfunction

  task automatic tick(input logic e, input logic [3:0] n, input logic r);
    en = e;
    nets = n;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b1, 4'hF, 1'b1);
    n_chk++;
    if ({v4, i4, c4, s4, l4, d4} !== 10'd0)
      $display("FAIL reset4 got=%h want=0", {v4, i4, c4, s4, l4, d4});
    else n_pass++;
    n_chk++;
    if ({v3, i3, c3, s3, l3, d3} !== 9'd0)
      $display("FAIL reset3 got=%h want=0", {v3, i3, c3, s3, l3, d3});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] n;
    n = '0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n[0] = ~n[0];
      tick(1'b1, n, 1'b1);
      n_chk++;
      if (v4 !== (i == 8))
        $display("FAIL basic_latency cyc=%0d got=%b want=%b", i, v4, i == 8);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({v4, i4, c4, l4, d4} !== {1'b1, 2'(k), (k == 0) ? 4'd8 : 4'd0,
                                    k == 3, 1'b0})
        $display("FAIL basic_entry%0d got=%h", k, {v4, i4, c4, l4, d4});
      else n_pass++;
      n_chk++;
      if (act3() !== exp3())
        $display("FAIL basic_model3 got=%h want=%h", act3(), exp3());
      else n_pass++;
      n[0] = ~n[0];
      tick(1'b1, n, 1'b1);
    end
    n_chk++;
    if (v4 !== 1'b0) $display("FAIL basic_end got=%b want=0", v4);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] n;
    n = '0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n[0] = ~n[0];
      tick(1'b1, n, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if ({v4, i4, c4} !== {1'b1, 2'd0, 4'd8})
        $display("FAIL bp_hold%0d got=%h want=%h", i, {v4, i4, c4}, 7'h48);
      else n_pass++;
      if (i < 5) tick(1'b0, n, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({v4, i4, c4} !== {1'b1, 2'(k), (k == 0) ? 4'd8 : 4'd0})
        $display("FAIL bp_xfer%0d got=%h", k, {v4, i4, c4});
      else n_pass++;
      tick(1'b0, n, 1'b1);
    end
    n_chk++;
    if ({v4, d4} !== 2'b00) $display("FAIL bp_end got=%b want=00", {v4, d4});
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [3:0] n;
    n = 4'b0101;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n[1] = ~n[1];
      tick(1'b1, n, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({v3, c3, s3} !== ((k == 1) ? 5'b1_111_1 : 5'b1_000_0))
        $display("FAIL sat3_idx%0d got=%b", k, {v3, c3, s3});
      else n_pass++;
      n_chk++;
      if ({c4, s4} !== ((k == 1) ? 5'b1000_0 : 5'b0000_0))
        $display("FAIL sat4_idx%0d got=%b", k, {c4, s4});
      else n_pass++;
      tick(1'b0, n, 1'b1);
    end
  endtask

  task automatic test_dropped();
    logic [3:0] hist[9];
    logic [3:0] n;
    int first[N];
    do_reset();
    for (int i = 0; i < 17; i++) begin
      n = 4'($urandom);
      if (i < 9) hist[i] = n;
      tick(1'b1, n, 1'b0);
      if (i == 8 || i == 16) begin
        n_chk++;
        if (d4 !== (i == 16))
          $display("FAIL drop_flag cyc=%0d got=%b want=%b", i, d4, i == 16);
        else n_pass++;
      end
    end
    foreach (first[j]) begin
      first[j] = 0;
      for (int i = 1; i < 9; i++)
        if (hist[i][j] != hist[i-1][j]) first[j]++;
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({v4, i4, c4, d4} !== {1'b1, 2'(k), 4'(first[k]), 1'b1})
        $display("FAIL drop_drain%0d got=%h want_cnt=%0d",
                 k, {v4, i4, c4, d4}, first[k]);
      else n_pass++;
      tick(1'b0, 4'h0, 1'b1);
    end
  endtask

  task automatic test_en_gap();
    logic [3:0] n;
    logic e;
    n = '0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      n[0] = ~n[0];
      e = !(i >= 4 && i <= 6);
      tick(e, n, 1'b0);
      if (i >= 11) begin
        n_chk++;
        if (v4 !== (i == 12))
          $display("FAIL gap_latency cyc=%0d got=%b want=%b", i, v4, i == 12);
        else n_pass++;
      end
    end
    n_chk++;
    if ({i4, c4} !== {2'd0, 4'd8})
      $display("FAIL gap_count got=%0d want=8", c4);
    else n_pass++;
    tick(1'b0, n, 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    logic [3:0] n;
    n = '0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n[0] = ~n[0];
      tick(1'b1, n, 1'b0);
    end
    tick(1'b0, n, 1'b1);
    tick(1'b0, n, 1'b1);
    n_chk++;
    if ({v4, i4} !== 3'b110) $display("FAIL rmd_pre got=%b want=110", {v4, i4});
    else n_pass++;
    rst_n = 1'b0;
    n[0] = ~n[0];
    tick(1'b1, n, 1'b1);
    rst_n = 1'b1;
    n_chk++;
    if ({v4, d4} !== 2'b00) $display("FAIL rmd_post got=%b want=00", {v4, d4});
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n[2] = ~n[2];
      tick(1'b1, n, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({v4, i4, c4} !== {1'b1, 2'(k), (k == 2) ? 4'd8 : 4'd0})
        $display("FAIL rmd_snap%0d got=%h", k, {v4, i4, c4});
      else n_pass++;
      tick(1'b0, n, 1'b1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      tick($urandom_range(0, 9) != 0, 4'($urandom), 1'($urandom));
      n_chk++;
      if (act4() !== exp4())
        $display("FAIL rand4 cyc=%0d got=%h want=%h", i, act4(), exp4());
      else n_pass++;
      n_chk++;
      if (act3() !== exp3())
        $display("FAIL rand3 cyc=%0d got=%h want=%h", i, act3(), exp3());
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_dropped();
    test_en_gap();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
